// File: rtl/muldiv_iterative_unit_if.sv
// rtl/muldiv_iterative_unit_if.sv - request/response bundle between execute stage and the M-extension unit
interface muldiv_iterative_unit_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, operand1, operand2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, operand1, operand2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_iterative_unit.sv
// rtl/muldiv_iterative_unit.sv - shared iterative engine for RV MUL/MULH*/DIV*/REM*
module muldiv_iterative_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input logic                    clk,
    input logic                    rst,
    muldiv_iterative_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam int PW = XLEN + MUL_STEP;
    localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_STEP - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;

    logic [2:0]      op_q;
    logic [XLEN-1:0] fixed_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] result_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_a_q;
    logic            neg_b_q;

    logic            accept;
    logic            finish;
    logic [CW-1:0]   last_cnt;

    logic            sgn1, sgn2, neg1, neg2, is_div, div_zero, div_ovf, fast;
    logic [XLEN-1:0] mag1, mag2, fast_res;

    always_comb begin
        is_div   = bus.funct3[2];
        sgn1     = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        sgn2     = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
        neg1     = sgn1 & bus.operand1[XLEN-1];
        neg2     = sgn2 & bus.operand2[XLEN-1];
        mag1     = neg1 ? -bus.operand1 : bus.operand1;
        mag2     = neg2 ? -bus.operand2 : bus.operand2;
        div_zero = is_div && (bus.operand2 == '0);
        div_ovf  = is_div && !bus.funct3[0] && (bus.operand1 == INT_MIN) && (bus.operand2 == '1);
        fast     = div_zero || div_ovf;
        // funct3[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero) begin
            fast_res = bus.funct3[1] ? bus.operand1 : '1;
        end else begin
            fast_res = bus.funct3[1] ? '0 : bus.operand1;
        end
    end

    logic [MUL_STEP-1:0] digit;
    logic [PW-1:0]       partial, msum;
    logic [XLEN:0]       rem_sh, diff;
    logic [XLEN-1:0]     acc_nxt, lo_nxt;
    logic [2*XLEN-1:0]   prod, prod_s;
    logic [XLEN-1:0]     quo_s, rem_s, final_res;

    // acc:lo is the product (high:low) for multiplies, remainder:quotient for divides
    always_comb begin
        digit   = lo_q[MUL_STEP-1:0];
        partial = PW'(fixed_q) * PW'(digit);
        msum    = PW'(acc_q) + partial;
        rem_sh  = {acc_q, lo_q[XLEN-1]};
        diff    = rem_sh - {1'b0, fixed_q};
        if (op_q[2]) begin
            if (!diff[XLEN]) begin
                acc_nxt = diff[XLEN-1:0];
                lo_nxt  = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = rem_sh[XLEN-1:0];
                lo_nxt  = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = msum[PW-1:MUL_STEP];
            lo_nxt  = {msum[MUL_STEP-1:0], lo_q[XLEN-1:MUL_STEP]};
        end
        prod   = {acc_nxt, lo_nxt};
        prod_s = neg_a_q ? -prod : prod;
        quo_s  = neg_a_q ? -lo_nxt : lo_nxt;
        rem_s  = neg_b_q ? -acc_nxt : acc_nxt;
        case (op_q)
            3'b000:                 final_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo_s;
            default:                final_res = rem_s;
        endcase
    end

    assign last_cnt = op_q[2] ? DIV_LAST : MUL_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    accept  = 1'b1;
                    state_d = fast ? DONE : CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == last_cnt) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            fixed_q  <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_q    <= bus.funct3;
            fixed_q <= is_div ? mag2 : mag1;
            lo_q    <= is_div ? mag1 : mag2;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_a_q <= neg1 ^ neg2;
            neg_b_q <= neg1;
            if (fast) begin
                result_q <= fast_res;
            end
        end else if (state_q == CALC && !bus.flush) begin
            acc_q <= acc_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (finish) begin
                result_q <= final_res;
            end
        end
    end

    assign bus.busy   = (state_q == CALC);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_iterative_unit.sv
// tb/tb_muldiv_iterative_unit.sv - randomized and directed checks of muldiv_iterative_unit against an arithmetic model
module tb_muldiv_iterative_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        en4 = 1'b1;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op1 = 32'd0;
    logic [31:0] op2 = 32'd0;
    logic [31:0] prev_res = 32'd0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    muldiv_iterative_unit_if #(.XLEN(32)) bus1 ();
    muldiv_iterative_unit_if #(.XLEN(32)) bus4 ();

    assign bus1.start    = start;
    assign bus1.funct3   = funct3;
    assign bus1.operand1 = op1;
    assign bus1.operand2 = op2;
    assign bus1.flush    = flush;
    assign bus4.start    = start & en4;
    assign bus4.funct3   = funct3;
    assign bus4.operand1 = op1;
    assign bus4.operand2 = op2;
    assign bus4.flush    = flush;

    muldiv_iterative_unit #(.XLEN(32), .MUL_STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    muldiv_iterative_unit #(.XLEN(32), .MUL_STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int step);
        if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        if (f[2]) return 33;
        return 32 / step + 1;
    endfunction

    // caller is at a negedge; start is presented for exactly one cycle
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e, r1, r4;
        int l1, l4, d1, d4, n1, n4, be1, be4;
        e = ref_result(f, a, b);
        l1 = exp_lat(f, a, b, 1);
        l4 = exp_lat(f, a, b, 4);
        d1 = -1; d4 = -1; n1 = 0; n4 = 0; be1 = 0; be4 = 0; r1 = '0; r4 = '0;
        funct3 = f; op1 = a; op2 = b; start = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (bus1.done) begin n1++; d1 = i; r1 = bus1.result; end
            if (bus4.done) begin n4++; d4 = i; r4 = bus4.result; end
            if (bus1.busy !== (i < l1)) be1++;
            if (bus4.busy !== (i < l4)) be4++;
        end
        check($sformatf("res_s1 f%0d %h %h", f, a, b), r1, e);
        check("lat_s1", d1, l1);
        check("ndone_s1", n1, 1);
        check("busy_s1", be1, 0);
        check("hold_s1", bus1.result, e);
        check($sformatf("res_s4 f%0d %h %h", f, a, b), r4, e);
        check("lat_s4", d4, l4);
        check("ndone_s4", n4, 1);
        check("busy_s4", be4, 0);
        prev_res = e;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 20));
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nd, nb, d_first, d_second;
        logic [31:0] r_first, r_second, ea, eb;
        logic [2:0]  rf;
        repeat (3) @(negedge clk);
        check("rst_busy", {bus1.busy, bus4.busy}, 2'b00);
        check("rst_done", {bus1.done, bus4.done}, 2'b00);
        check("rst_res1", bus1.result, 32'd0);
        check("rst_res4", bus4.result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        check("mul_const", bus1.result, 32'hFFFF_FFEB);

        // reset in the middle of a multiply
        funct3 = 3'd0; op1 = 32'd123; op2 = 32'd456; start = 1'b1; nd = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 5) rst = 1'b1;
            if (i == 6) begin
                rst = 1'b0;
                check("midrst_busy", {bus1.busy, bus4.busy}, 2'b00);
                check("midrst_res1", bus1.result, 32'd0);
                check("midrst_res4", bus4.result, 32'd0);
            end
            if (i >= 6 && (bus1.done || bus4.done)) nd++;
        end
        check("midrst_ndone", nd, 0);
        prev_res = 32'd0;

        run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd5, 32'd100, 32'd7);
        check("divu_const", bus1.result, 32'd14);
        run_op(3'd7, 32'd100, 32'd7);
        run_op(3'd5, 32'd5, 32'd0);
        run_op(3'd7, 32'd5, 32'd0);
        check("remu0_const", bus1.result, 32'd5);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // flush during a divide, then an immediate new start
        funct3 = 3'd4; op1 = 32'd1000; op2 = 32'd3; start = 1'b1; nd = 0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 10) flush = 1'b1;
            if (bus1.done || bus4.done) nd++;
        end
        flush = 1'b0;
        check("flush_ndone", nd, 0);
        check("flush_busy", {bus1.busy, bus4.busy}, 2'b00);
        check("flush_res1", bus1.result, prev_res);
        check("flush_res4", bus4.result, prev_res);
        run_op(3'd6, 32'hFFFF_FF00, 32'd7);

        // flush together with start: request dropped
        funct3 = 3'd5; op1 = 32'd9; op2 = 32'd3; start = 1'b1; flush = 1'b1; nd = 0; nb = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin start = 1'b0; flush = 1'b0; end
            if (bus1.done || bus4.done) nd++;
            if (bus1.busy || bus4.busy) nb++;
        end
        check("fs_ndone", nd, 0);
        check("fs_busy", nb, 0);
        check("fs_res1", bus1.result, prev_res);

        // start held high with changing operands on the step-1 unit only
        en4 = 1'b0;
        rf = 3'd3; ea = ref_result(rf, 32'hDEAD_BEEF, 32'h1234_5678);
        eb = ref_result(rf, 32'hCAFE_F00D, 32'h0BAD_F00D);
        funct3 = rf; op1 = 32'hDEAD_BEEF; op2 = 32'h1234_5678; start = 1'b1;
        nd = 0; d_first = -1; d_second = -1; r_first = '0; r_second = '0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (bus1.done) begin
                nd++;
                if (nd == 1) begin d_first = i; r_first = bus1.result; end
                else begin d_second = i; r_second = bus1.result; end
            end
            if (i == 34) check("held_idle_busy", bus1.busy, 1'b0);
            if (i < 33) begin op1 = $urandom; op2 = $urandom; end
            if (i == 33) begin op1 = 32'hCAFE_F00D; op2 = 32'h0BAD_F00D; end
            if (i == 35) start = 1'b0;
        end
        check("held_ndone", nd, 2);
        check("held_lat1", d_first, 33);
        check("held_res1", r_first, ea);
        check("held_lat2", d_second, 67);
        check("held_res2", r_second, eb);
        en4 = 1'b1;

        for (int k = 0; k < 40; k++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
